// File: rtl/multi_ctx_pc_if.sv
// Fetch-side bus of the multi-context PC: fetch handshake, context run
// enables, redirect port and the selected-PC outputs.
interface multi_ctx_pc_if #(
  parameter int NUM_CTX = 2,
  parameter int PC_W    = 32
);
  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  logic               pc_EN;
  logic [NUM_CTX-1:0] ctx_active;
  logic               redirect_valid;
  logic [CTX_W-1:0]   redirect_ctx;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    pc_out;
  logic [CTX_W-1:0]   pc_ctx;
  logic               pc_valid;
  logic               misalign;

  // Fetch stage / redirect source side
  modport master (
    output pc_EN, ctx_active, redirect_valid, redirect_ctx, redirect_pc,
    input  pc_out, pc_ctx, pc_valid, misalign
  );

  // PC block side
  modport slave (
    input  pc_EN, ctx_active, redirect_valid, redirect_ctx, redirect_pc,
    output pc_out, pc_ctx, pc_valid, misalign
  );
endinterface

// File: rtl/multi_ctx_pc.sv
// Multi-context program counter: one PC per hardware context, round-robin
// selection among active contexts, advance on fetch, redirect to any context.
// Optional macro PC_ALIGN_CHECK_EN: misaligned redirects are rejected and
// flagged on misalign for one cycle; otherwise the low two bits are cleared.
module multi_ctx_pc #(
  parameter int              NUM_CTX    = 2,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] PC_INIT    = '0,
  parameter logic [PC_W-1:0] CTX_STRIDE = PC_W'(32'h200),
  parameter logic [PC_W-1:0] PC_INC     = PC_W'(4)
) (
  input  logic           CLK,
  input  logic           RST,
  multi_ctx_pc_if.slave  bus
);
  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  // Reset vector of context i, wrapping modulo 2^PC_W
  function automatic logic [PC_W-1:0] rst_vec(input int i);
    return PC_INIT + PC_W'(i) * CTX_STRIDE;
  endfunction

  logic [NUM_CTX-1:0][PC_W-1:0] pc_q, pc_d;
  logic [CTX_W-1:0]             sel_q, sel_d;
  logic                         fire;
  logic                         ctx_ok;
  logic                         rd_accept;
  logic [PC_W-1:0]              rd_pc;

  assign bus.pc_out   = pc_q[sel_q];
  assign bus.pc_ctx   = sel_q;
  assign bus.pc_valid = bus.ctx_active[sel_q];

  // A fetch only counts when the selected context is actually running
  assign fire   = bus.pc_EN && bus.pc_valid;
  assign ctx_ok = {1'b0, bus.redirect_ctx} < (CTX_W+1)'(NUM_CTX);

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;
  logic bad_align;

  assign bad_align    = bus.redirect_pc[1:0] != 2'b00;
  assign rd_accept    = bus.redirect_valid && ctx_ok && !bad_align;
  assign rd_pc        = bus.redirect_pc;
  assign bus.misalign = misalign_q;

  // One-cycle flag for each rejected (misaligned, in-range) redirect
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) misalign_q <= 1'b0;
    else     misalign_q <= bus.redirect_valid && ctx_ok && bad_align;
  end
`else
  assign rd_accept    = bus.redirect_valid && ctx_ok;
  assign rd_pc        = {bus.redirect_pc[PC_W-1:2], 2'b00};
  assign bus.misalign = 1'b0;
`endif

  // Per-context next PC: redirect beats increment, otherwise hold
  always_comb begin
    pc_d = pc_q;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (rd_accept && int'(bus.redirect_ctx) == i)
        pc_d[i] = rd_pc;
      else if (fire && int'(sel_q) == i)
        pc_d[i] = pc_q[i] + PC_INC;
    end
  end

  // Round-robin search starting after sel_q, ending on sel_q itself;
  // holds when nothing is active or when no advance is requested
  always_comb begin
    logic found;
    logic adv;
    int   j;
    sel_d = sel_q;
    found = 1'b0;
    adv   = fire || !bus.pc_valid;
    j     = 0;
    for (int k = 1; k <= NUM_CTX; k++) begin
      j = (int'(sel_q) + k) % NUM_CTX;
      if (adv && !found && bus.ctx_active[j]) begin
        sel_d = CTX_W'(j);
        found = 1'b1;
      end
    end
  end

  // PC and selector state, async reset to per-context vectors
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_CTX; i++) pc_q[i] <= rst_vec(i);
      sel_q <= '0;
    end else begin
      pc_q  <= pc_d;
      sel_q <= sel_d;
    end
  end
endmodule
